// File: rtl/mem_responder.sv
// mem_responder: responder end of the PicoRV32 native memory interface.
// Word-organised RAM with a programmable response latency (WAIT_CYCLES).
// Optional feature macro MEM_RESPONDER_RANGE_CHECK_EN: requests outside
// [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4) complete with mem_err=1, read zero
// and drop writes. Without it, upper address bits alias and mem_err stays 0.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state;
  state_t             state_nx;
  logic [3:0]         cnt;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        ram [DEPTH_WORDS];

  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [3:0]         req_wstrb;
  logic [31:0]        offset;
  logic [IDX_W-1:0]   idx;
  logic               in_range;
  logic               fire;
  logic               ready_d;
  logic               err_d;
  logic               ram_we;
  logic               rd_en;
  logic               unused;

  // A zero-wait request completes on its accepting edge, so the live bus is
  // used in IDLE; every later completion uses the copy latched at accept.
  always_comb begin
    req_addr  = addr_q;
    req_wdata = wdata_q;
    req_wstrb = wstrb_q;
    if (state == S_IDLE) begin
      req_addr  = mem_addr;
      req_wdata = mem_wdata;
      req_wstrb = mem_wstrb;
    end
  end

  assign offset = req_addr - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  assign in_range = (offset < SPAN);
`else
  assign in_range = 1'b1;
`endif

  assign unused = ^{mem_instr, offset[31:IDX_W+2], offset[1:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && mem_valid) begin
        cnt <= WAIT_INIT;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && mem_valid) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (mem_valid) state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!mem_valid) state_nx = S_IDLE;
        else if (cnt == 4'd1) state_nx = S_RESP;
      end
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    fire    = (state_nx == S_RESP);
    ready_d = fire;
    err_d   = fire && !in_range;
    ram_we  = fire && in_range && (req_wstrb != '0);
    rd_en   = fire && in_range && (req_wstrb == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= ready_d;
      mem_err   <= err_d;
      mem_rdata <= rd_en ? ram[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_wstrb[i]) ram[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule
